dec_scan_enab: RTL and testbench
================================

Name: dec_scan_enab

Overview:
- Parametrised, registered successor to the 4-to-16 enabled decoder.
- Two modes:
  - Direct: latch a select value and drive the one-hot output.
  - Scan: step the one-hot output through every line, holding each for a programmable dwell time.
- Used for row/channel strobing, where a downstream block needs timed one-hot selects without the CPU rewriting the index.

Parameters:
- SEL_W, 4, select width in bits. Output width is 2**SEL_W (localparam OUT_W).
- DWELL_W, 8, width of the dwell-count input and of the internal dwell counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enab  in  1  global enable. Low forces the output to all-zero and the FSM to IDLE.
- mode  in  1  0 = direct, 1 = scan. Sampled only on an accepted load.
- load  in  1  single-cycle command strobe. Accepted when enab=1.
- inp  in  SEL_W  direct select, or scan start index. Sampled on an accepted load.
- dwell  in  DWELL_W  hold time per line minus one. Sampled on an accepted load.
- d  out  OUT_W  registered one-hot output, or all-zero.
- cur  out  SEL_W  registered index currently driven.
- busy  out  1  high while in SCAN.
- wrap  out  1  one-cycle pulse when the scan index rolls from OUT_W-1 to 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - d=0, cur=0, busy=0, wrap=0.
  - Dwell counter = 0, state = IDLE.
- FSM states: IDLE, DIRECT, SCAN. All outputs are registered.
- Accepted load = enab & load, in any state. Load restarts the block, including mid-scan.
- Load with mode=0:
  - Next state DIRECT.
  - Next cycle: cur=inp, d=1<<inp, busy=0.
  - Latency is one clock from the load edge.
- Load with mode=1:
  - Next state SCAN.
  - Next cycle: cur=inp, d=1<<inp, busy=1.
  - Dwell counter loaded with the sampled dwell value.
- SCAN:
  - Each cycle with dwell counter ≠ 0: decrement the counter.
  - Cycle with counter = 0: cur = cur+1 modulo OUT_W, d follows, counter reloads the latched dwell value.
  - Each line is therefore held dwell+1 cycles. dwell=0 advances every cycle.
  - Roll from OUT_W-1 to 0: wrap=1 for exactly the cycle in which cur becomes 0. Otherwise wrap=0.
- DIRECT: output holds until the next load or until enab falls.
- enab low, any state:
  - Next cycle: d=0, busy=0, wrap=0, state IDLE.
  - cur retains its last value.
  - load is ignored while enab=0.
- Re-assertion of enab alone does not drive d. A load is required.
- Simultaneous load and scan advance: load wins.
- Simultaneous load and wrap condition: load wins, and no wrap pulse is produced.
- Widths:
  - Index arithmetic is SEL_W bits with natural wrap.
  - Dwell counter is DWELL_W bits and never underflows.
- Invariant: d is exactly one-hot while in DIRECT or SCAN, and all-zero in IDLE.

Optional Feature:
- Macro: DEC_SCAN_ONESHOT_EN.
- Defined:
  - At the wrap point, SCAN stops after one full pass. cur returns to 0 with wrap=1 for one cycle; state goes to IDLE, d=0, busy=0.
  - A new load is needed to restart.
- Undefined:
  - Scan runs continuously, wrapping indefinitely, until load or enab low.

Test Plan:
- Reset mid-scan: SEL_W=4, run a scan, assert rst_n=0 asynchronously between clock edges.
  - d=0, cur=0, busy=0 immediately, without waiting for a clock.
- Direct mode: enab=1, load pulse, mode=0, inp=4'd9.
  - One clock later d=16'h0200, cur=9, busy=0.
  - Holds for 20 cycles with no further loads.
- Scan dwell: mode=1, inp=14, dwell=2.
  - d=16'h4000 for 3 cycles, then 16'h8000 for 3 cycles, then 16'h0001.
  - wrap=1 only in the first cycle of cur=0.
  - Without DEC_SCAN_ONESHOT_EN, scanning continues.
- Enable drop mid-scan: during a scan at cur=5, drop enab for 2 cycles, then raise it.
  - d=0 and busy=0 one cycle after the drop. cur stays 5.
  - d stays 0 after enab returns, until a load.
  - A load issued while enab=0 has no effect.
- Load during scan: at cur=3 with the counter mid-count, load mode=0, inp=12.
  - Next cycle d=16'h1000, busy=0, no wrap pulse.
  - Separately, a load coinciding with the 15→0 roll gives wrap=0.
- Oneshot and parametrisation: build with DEC_SCAN_ONESHOT_EN and SEL_W=2; scan with inp=0, dwell=0.
  - d sequence: 1, 2, 4, 8.
  - Then cur=0 with wrap=1 and d=0 in that same cycle, and busy=0 thereafter.

Source files
------------

// File: rtl/dec_scan_enab.sv
// dec_scan_enab: registered, parametrised one-hot decoder with a scan mode.
//   Direct mode latches a select index and drives 1 << index.
//   Scan mode walks the one-hot output through every line, holding each line
//   for (dwell + 1) cycles, and pulses wrap when the index rolls back to 0.
// Optional build macro: DEC_SCAN_ONESHOT_EN -- when defined, a scan stops
//   after reaching the wrap point (cur = 0, wrap = 1, d = 0, back to IDLE).
//
// Command semantics: there is no valid/ready pair. 'load' is a one-cycle
// strobe that is always accepted when 'enab' is high, in every state, and
// restarts the block. While 'enab' is low every command is dropped.
module dec_scan_enab #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enab,
  input  logic                 mode,
  input  logic                 load,
  input  logic [SEL_W-1:0]     inp,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**SEL_W-1:0]  d,
  output logic [SEL_W-1:0]     cur,
  output logic                 busy,
  output logic                 wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [OUT_W-1:0]   d_q, d_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   next_idx;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = OUT_W'(1) << idx;
  endfunction

  assign next_idx = cur_q + SEL_W'(1);

  // Next-state logic: enable drop beats load, load beats scan advance.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    d_d     = d_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    if (!enab) begin
      // cur is deliberately kept so software can see where the scan stopped.
      state_d = ST_IDLE;
      d_d     = '0;
      busy_d  = 1'b0;
    end else if (load) begin
      cur_d   = inp;
      d_d     = onehot(inp);
      dwell_d = dwell;
      if (mode) begin
        state_d = ST_SCAN;
        busy_d  = 1'b1;
        cnt_d   = dwell;
      end else begin
        state_d = ST_DIRECT;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    end else if (state_q == ST_SCAN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DWELL_W'(1);
      end else begin
        cur_d  = next_idx;
        d_d    = onehot(next_idx);
        cnt_d  = dwell_q;
        wrap_d = (next_idx == '0);
`ifdef DEC_SCAN_ONESHOT_EN
        if (next_idx == '0) begin
          state_d = ST_IDLE;
          d_d     = '0;
          busy_d  = 1'b0;
        end
`endif
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

  assign d    = d_q;
  assign cur  = cur_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_enab.sv
// Bench for dec_scan_enab: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
// Build with DEC_SCAN_ONESHOT_EN to exercise the one-shot scan on SEL_W=2.
module tb_dec_scan_enab;

`ifdef DEC_SCAN_ONESHOT_EN
  localparam int SEL_W = 2;
`else
  localparam int SEL_W = 4;
`endif
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 2 ** SEL_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enab = 1'b0;
  logic               mode = 1'b0;
  logic               load = 1'b0;
  logic [SEL_W-1:0]   inp = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [OUT_W-1:0]   d;
  logic [SEL_W-1:0]   cur;
  logic               busy;
  logic               wrap;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  dec_scan_enab #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .enab(enab), .mode(mode), .load(load),
    .inp(inp), .dwell(dwell), .d(d), .cur(cur), .busy(busy), .wrap(wrap)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural model: position in a scan is derived from the number of
  // cycles since the load, divided by the per-line hold time.
  int m_st = 0;        // 0 off, 1 direct, 2 scanning
  int m_cur = 0;
  int m_start = 0;
  int m_dw = 0;
  int m_elapsed = 0;
  bit m_wrap = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_cur = 0; m_wrap = 1'b0; m_elapsed = 0;
    end else begin
      m_wrap = 1'b0;
      if (!enab) begin
        m_st = 0;
      end else if (load) begin
        m_st      = mode ? 2 : 1;
        m_start   = int'(inp);
        m_dw      = int'(dwell);
        m_elapsed = 0;
        m_cur     = int'(inp);
      end else if (m_st == 2) begin
        m_elapsed++;
        if (m_elapsed % (m_dw + 1) == 0) begin
          m_cur = (m_start + m_elapsed / (m_dw + 1)) % OUT_W;
          if (m_cur == 0) begin
            m_wrap = 1'b1;
`ifdef DEC_SCAN_ONESHOT_EN
            m_st = 0;
`endif
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      logic [OUT_W-1:0] exp_d;
      exp_d = (m_st == 0) ? '0 : (OUT_W'(1) << m_cur);
      chk("model_d", 64'(d), 64'(exp_d));
      chk("model_cur", 64'(cur), 64'(m_cur));
      chk("model_busy", 64'(busy), 64'(m_st == 2));
      chk("model_wrap", 64'(wrap), 64'(m_wrap));
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input bit m, input int i, input int dw);
    load  = 1'b1;
    mode  = m;
    inp   = SEL_W'(i);
    dwell = DWELL_W'(dw);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk_on = 1'b1;
    chk("rst_d", 64'(d), 64'h0);
    chk("rst_cur", 64'(cur), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_wrap", 64'(wrap), 64'h0);
    rst_n = 1'b1;
    cyc(1);
    enab = 1'b1;
    cyc(2);
    chk("enab_only_d", 64'(d), 64'h0);

`ifndef DEC_SCAN_ONESHOT_EN
    // direct mode, held for 20 cycles
    do_load(1'b0, 9, 0);
    chk("direct_d", 64'(d), 64'h0200);
    chk("direct_cur", 64'(cur), 64'd9);
    chk("direct_busy", 64'(busy), 64'h0);
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk("direct_hold", 64'(d), 64'h0200);
    end

    // scan with dwell 2 across the wrap point
    do_load(1'b1, 14, 2);
    for (int k = 0; k < 3; k++) begin
      chk("scan_l14", 64'(d), 64'h4000);
      cyc(1);
    end
    for (int k = 0; k < 3; k++) begin
      chk("scan_l15", 64'(d), 64'h8000);
      chk("scan_nowrap", 64'(wrap), 64'h0);
      cyc(1);
    end
    chk("scan_l0", 64'(d), 64'h0001);
    chk("scan_wrap", 64'(wrap), 64'h1);
    cyc(1);
    chk("scan_wrap_once", 64'(wrap), 64'h0);
    cyc(2);
    chk("scan_continue_cur", 64'(cur), 64'd1);
    chk("scan_continue_busy", 64'(busy), 64'h1);

    // enable drop at cur=5, with an ignored load while low
    do_load(1'b1, 3, 1);
    cyc(4);
    chk("drop_pre_cur", 64'(cur), 64'd5);
    enab = 1'b0; load = 1'b1; mode = 1'b0; inp = SEL_W'(9);
    cyc(1);
    chk("drop_d", 64'(d), 64'h0);
    chk("drop_busy", 64'(busy), 64'h0);
    chk("drop_cur", 64'(cur), 64'd5);
    cyc(1);
    chk("drop_load_ignored", 64'(d), 64'h0);
    load = 1'b0; enab = 1'b1;
    cyc(3);
    chk("reenab_d", 64'(d), 64'h0);
    chk("reenab_cur", 64'(cur), 64'd5);

    // load during a scan, counter mid-count at cur=3
    do_load(1'b1, 0, 3);
    cyc(13);
    chk("mid_cur", 64'(cur), 64'd3);
    do_load(1'b0, 12, 0);
    chk("mid_load_d", 64'(d), 64'h1000);
    chk("mid_load_busy", 64'(busy), 64'h0);
    chk("mid_load_wrap", 64'(wrap), 64'h0);

    // load on the same edge as the 15 -> 0 roll
    do_load(1'b1, 15, 0);
    do_load(1'b0, 7, 0);
    chk("roll_load_wrap", 64'(wrap), 64'h0);
    chk("roll_load_d", 64'(d), 64'h0080);
`else
    // one-shot pass on a 2-bit select
    do_load(1'b1, 0, 0);
    chk("os_d0", 64'(d), 64'h1);
    cyc(1);
    chk("os_d1", 64'(d), 64'h2);
    cyc(1);
    chk("os_d2", 64'(d), 64'h4);
    cyc(1);
    chk("os_d3", 64'(d), 64'h8);
    chk("os_busy_run", 64'(busy), 64'h1);
    cyc(1);
    chk("os_end_cur", 64'(cur), 64'h0);
    chk("os_end_wrap", 64'(wrap), 64'h1);
    chk("os_end_d", 64'(d), 64'h0);
    chk("os_end_busy", 64'(busy), 64'h0);
    cyc(2);
    chk("os_after_busy", 64'(busy), 64'h0);
    chk("os_after_wrap", 64'(wrap), 64'h0);
`endif

    // asynchronous reset in the middle of a scan
    do_load(1'b1, 2, 1);
    cyc(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d", 64'(d), 64'h0);
    chk("arst_cur", 64'(cur), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // randomized phase
    for (int k = 0; k < 1500; k++) begin
      enab  = ($urandom_range(0, 15) != 0);
      load  = ($urandom_range(0, 9) == 0);
      mode  = 1'($urandom_range(0, 1));
      inp   = SEL_W'($urandom_range(0, OUT_W - 1));
      dwell = ($urandom_range(0, 3) == 0) ? DWELL_W'($urandom_range(0, 20))
                                          : DWELL_W'($urandom_range(0, 2));
      @(negedge clk);
    end
    load = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
